aksp_mbist_mbisr: RTL and testbench
===================================

# aksp_mbist_mbisr

Memory built-in self-test and self-repair (MBIST/MBISR) block. It contains a 16×8 register-file SRAM model with optional stuck-at fault injection. On a start pulse it runs March C- over the array. It repairs one faulty word with a single spare word, and reports done, fail and repair status on the TinyTapeout-style pin bundle.

## Interface
- No parameters. Array depth is fixed at 16 words, width at 8 bits, with 1 spare word.
- One clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset; clears all state.
- ena  input  1  TinyTapeout enable; ignored.
- ui_in  input  8  [0] start; [1] inject_en; [2] stuck value; [3] second-fault enable; [7:4] fault address.
- uo_out  output  8  [0] done; [1] fail; [2] repaired; [3] busy; [7:4] first failing address.
- uio_in  input  8  unused.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0.

## Operation
- States: IDLE, MARCH, REPAIR, DONE.
- Start is sampled from ui_in[0] only in IDLE or DONE.
  - A start sample clears fail, repaired, the fault address, remap and the error flags.
  - It latches ui_in[3:1] and ui_in[7:4] as the fault configuration.
  - It then enters MARCH with pass=1.
- March C- runs as six elements, 16 addresses each, 160 ops total, one op per clock:
  - ⇑w0
  - ⇑(r0,w1)
  - ⇑(r1,w0)
  - ⇓(r0,w1)
  - ⇓(r1,w0)
  - ⇓r0
- Data is 8'h00 for a 0 and 8'hFF for a 1.
- Reads are asynchronous. Compare happens in the same cycle as the op. Writes are synchronous.
- Fault model (main array only; the spare is always fault-free):
  - If inject_en is set, bit 0 of the word at the fault address always reads as the stuck value.
  - If second-fault enable is also set, the same fault applies at address ~fault_addr.
- Mismatch handling in pass 1:
  - First mismatch: record its address in uo_out[7:4] and set the found flag.
  - A mismatch at a different address sets the unrepairable flag.
- End of pass 1:
  - No found flag: go to DONE with fail=0 and repaired=0.
  - Unrepairable flag set: go to DONE with fail=1.
  - Otherwise: go to REPAIR.
- REPAIR lasts one cycle. It enables the remap so that every access to the recorded address goes to the spare word. It resets the address and element counters, sets pass=2 and returns to MARCH.
- End of pass 2:
  - Any mismatch in pass 2: fail=1, repaired=0.
  - Otherwise: repaired=1, fail=0.
  - Then go to DONE.
- busy (uo_out[3]) is high in MARCH and REPAIR.
- done (uo_out[0]) is high only in DONE and holds until the next start or reset.

## Timing
- Reset values:
  - uo_out = 8'h00.
  - State is IDLE.
  - Remap is off.
  - uio_out and uio_oe are always 0.
- Let E0 be the edge that samples start=1.
  - Pass 1 ops execute at edges E0+1 … E0+160.
  - With no fault or an unrepairable fault, done=1 is visible after edge E0+160.
  - With a repairable fault, REPAIR occupies E0+161, pass-2 ops execute at E0+162 … E0+321, and done=1 is visible after edge E0+321.
- Start is ignored while busy. A held start in DONE restarts the test every time it is sampled.
- Reset mid-run aborts immediately to IDLE with all outputs 0. Memory contents are not cleared; the test rewrites every word.
- Address counting:
  - ⇑ elements count 0→15.
  - ⇓ elements count 15→0.
  - The element advances on the wrap of the address counter.

## Test plan
- No fault: start pulse with ui_in=8'h01 → done=1 after 160 cycles; fail=0, repaired=0, uo_out[7:4]=0.
- Stuck-at-0 at address 5: ui_in=8'h53 pulse (bit0 then cleared) → done after 321 cycles; repaired=1, fail=0, uo_out[7:4]=5.
- Stuck-at-1 at address 15: ui_in[7:4]=F, [2]=1, [1]=1 → repaired=1, fail=0, uo_out[7:4]=F.
- Double fault: address 3 and 12 via ui_in[3]=1 → done after 160 cycles; fail=1, repaired=0, uo_out[7:4]=3.
- Reset asserted 50 cycles into MARCH → uo_out=0 and IDLE immediately; a new start then completes normally.
- Back-to-back runs: start again in DONE with no fault after a repaired run → flags cleared, done after 160 cycles with fail=0, repaired=0.

Source files
------------

// File: rtl/aksp_mbist_mbisr.sv
// March C- MBIST over a 16x8 register file with one spare word.
// A single faulty word is remapped to the spare and the array is re-tested.
module aksp_mbist_mbisr (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {IDLE, MARCH, REPAIR, DONE} state_t;

    state_t     state, state_n;
    logic [7:0] mem [16];
    logic [7:0] spare;
    logic [3:0] cnt;
    logic [2:0] elem;
    logic       sub;
    logic       pass2;
    logic       found, unrep, err2;
    logic       fail, repaired, remap;
    logic [3:0] fail_addr;
    logic       inj, stuck, second;
    logic [3:0] faddr;

    logic       two_op, down, is_rd, is_wr;
    logic       exp_one, wr_one, to_spare, hit;
    logic       mis, step_done, last, start;
    logic       found_n, unrep_n, err_n;
    logic [3:0] addr;
    logic [7:0] raw, rd, wd;
    logic       unused_ok;

    assign unused_ok = &{1'b0, ena, uio_in};

    always_comb begin
        two_op    = (elem != 3'd0) && (elem != 3'd5);
        down      = (elem >= 3'd3);
        addr      = down ? ~cnt : cnt;
        is_rd     = (elem == 3'd5) || (two_op && !sub);
        is_wr     = !is_rd;
        exp_one   = (elem == 3'd2) || (elem == 3'd4);
        wr_one    = (elem == 3'd1) || (elem == 3'd3);
        wd        = {8{wr_one}};
        to_spare  = remap && (addr == fail_addr);
        raw       = to_spare ? spare : mem[addr];
        // Stuck bit only exists in the main array
        hit       = inj && !to_spare &&
                    ((addr == faddr) || (second && (addr == ~faddr)));
        rd        = {raw[7:1], hit ? stuck : raw[0]};
        mis       = (state == MARCH) && is_rd && (rd != {8{exp_one}});
        step_done = !two_op || sub;
        last      = (elem == 3'd5) && (cnt == 4'hF);
        start     = ui_in[0] && ((state == IDLE) || (state == DONE));
        found_n   = found || mis;
        unrep_n   = unrep || (mis && found && (addr != fail_addr));
        err_n     = err2 || mis;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start) state_n = MARCH;
            MARCH: begin
                if (last) begin
                    if (pass2)        state_n = DONE;
                    else if (unrep_n) state_n = DONE;
                    else if (found_n) state_n = REPAIR;
                    else              state_n = DONE;
                end
            end
            REPAIR: state_n = MARCH;
            DONE:   if (start) state_n = MARCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            elem      <= '0;
            sub       <= 1'b0;
            pass2     <= 1'b0;
            found     <= 1'b0;
            unrep     <= 1'b0;
            err2      <= 1'b0;
            fail      <= 1'b0;
            repaired  <= 1'b0;
            remap     <= 1'b0;
            fail_addr <= '0;
            inj       <= 1'b0;
            stuck     <= 1'b0;
            second    <= 1'b0;
            faddr     <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                cnt       <= '0;
                elem      <= '0;
                sub       <= 1'b0;
                pass2     <= 1'b0;
                found     <= 1'b0;
                unrep     <= 1'b0;
                err2      <= 1'b0;
                fail      <= 1'b0;
                repaired  <= 1'b0;
                remap     <= 1'b0;
                fail_addr <= '0;
                inj       <= ui_in[1];
                stuck     <= ui_in[2];
                second    <= ui_in[3];
                faddr     <= ui_in[7:4];
            end
            if (state == MARCH) begin
                sub <= two_op && !sub;
                if (step_done) begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'hF) elem <= elem + 3'd1;
                end
                if (mis) begin
                    if (pass2) begin
                        err2 <= 1'b1;
                    end else if (!found) begin
                        found     <= 1'b1;
                        fail_addr <= addr;
                    end else if (addr != fail_addr) begin
                        unrep <= 1'b1;
                    end
                end
                if (last) begin
                    if (pass2) begin
                        fail     <= err_n;
                        repaired <= !err_n;
                    end else if (unrep_n) begin
                        fail <= 1'b1;
                    end
                end
            end
            if (state == REPAIR) begin
                remap <= 1'b1;
                cnt   <= '0;
                elem  <= '0;
                sub   <= 1'b0;
                pass2 <= 1'b1;
            end
        end
    end

    // Array is not reset; every march rewrites all words before reading
    always_ff @(posedge clk) begin
        if ((state == MARCH) && is_wr) begin
            if (to_spare) spare <= wd;
            else          mem[addr] <= wd;
        end
    end

    assign uo_out  = {fail_addr, (state == MARCH) || (state == REPAIR),
                      repaired, fail, state == DONE};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_aksp_mbist_mbisr.sv
// Directed bench for aksp_mbist_mbisr: fault-free, repairable,
// unrepairable, reset abort and back-to-back runs.
module tb_aksp_mbist_mbisr;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    aksp_mbist_mbisr dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start, optionally poke start again mid-run, then wait for done.
    task automatic run(input string tag, input logic [7:0] ui,
                       input int exp_cyc, input logic [7:0] exp_uo,
                       input int poke);
        int n;
        @(negedge clk);
        ui_in = ui;
        @(posedge clk);
        #1;
        ui_in = ui & 8'hFE;
        check({tag, "_busy"}, int'(uo_out[3:0]), 4'b1000);
        n = 0;
        while (!uo_out[0] && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke)     ui_in = ui | 8'h01;
            if (n == poke + 1) ui_in = ui & 8'hFE;
        end
        check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_uo"}, int'(uo_out), int'(exp_uo));
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uo", int'(uo_out), 8'h00);
        check("reset_uio_out", int'(uio_out), 8'h00);
        check("reset_uio_oe", int'(uio_oe), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_uo", int'(uo_out), 8'h00);

        run("nofault", 8'h01, 160, 8'h01, 0);
        run("sa0_a5", 8'h53, 321, 8'h55, 0);
        run("sa1_aF", 8'hF7, 321, 8'hF5, 0);
        run("dbl_sa0_a3", 8'h3B, 160, 8'h33, 0);
        run("dbl_sa1_a3", 8'h3F, 160, 8'h33, 0);
        run("sa1_a0", 8'h07, 321, 8'h05, 0);
        run("b2b_nofault", 8'h01, 160, 8'h01, 0);
        run("busy_poke", 8'h93, 321, 8'h95, 20);

        // Abort mid-march with reset
        @(negedge clk);
        ui_in = 8'h53;
        @(posedge clk);
        #1;
        ui_in = 8'h52;
        repeat (50) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(uo_out[3]), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_uo", int'(uo_out), 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_uo", int'(uo_out), 8'h00);
        @(negedge clk);
        rst   = 1'b0;
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        check("post_rst_idle", int'(uo_out), 8'h00);
        run("after_rst", 8'h01, 160, 8'h01, 0);
        check("uio_out_end", int'(uio_out), 8'h00);
        check("uio_oe_end", int'(uio_oe), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
